// File: rtl/hdmi_timing_pkg.sv
// Shared types and timing constants for the HDMI TX raster sequencer.
// Defaults describe 640x480@60 with an 8-pixel preamble and a 2-pixel guard band.
package hdmi_timing_pkg;

    typedef enum logic [1:0] {
        CONTROL  = 2'b00,
        PREAMBLE = 2'b01,
        GUARD    = 2'b10,
        VIDEO    = 2'b11
    } period_mode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BLANK,
        ST_PREAMBLE,
        ST_GUARD,
        ST_ACTIVE
    } ctrl_state_t;

    localparam logic [3:0] CTL_VIDEO_PREAMBLE = 4'b0001;
    localparam int PRE_LEN = 8;
    localparam int GB_LEN  = 2;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FRONT  = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BACK   = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FRONT  = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BACK   = 33;

    localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

endpackage

// File: rtl/video_timing_counter.sv
// Horizontal/vertical raster counters. They park at the hold point until enable is seen,
// and expose the next position so the top can register outputs in step with the counters.
module video_timing_counter
    import hdmi_timing_pkg::*;
#(
    parameter int H_TOTAL = VGA_H_TOTAL,
    parameter int V_TOTAL = VGA_V_TOTAL,
    parameter int HOLD_H  = VGA_H_TOTAL - PRE_LEN - GB_LEN - 1
) (
    input  logic       pixelCLK,
    input  logic       reset,
    input  logic       enable,
    output logic [9:0] h,
    output logic [9:0] v,
    output logic [9:0] nextH,
    output logic [9:0] nextV,
    output logic       atHold
);

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] HOLD_X = 10'(HOLD_H);

    assign atHold = (h == HOLD_X) && (v == V_LAST);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        nextH = h;
        nextV = v;
        if (!atHold || enable) begin
            if (h == H_LAST) begin
                nextH = '0;
                nextV = (v == V_LAST) ? '0 : v + 10'd1;
            end else begin
                nextH = h + 10'd1;
            end
        end
    end

    always_ff @(posedge pixelCLK or posedge reset) begin
        if (reset) begin
            h <= HOLD_X;
            v <= V_LAST;
        end else begin
            h <= nextH;
            v <= nextV;
        end
    end

endmodule

// File: rtl/video_timing_ctrl.sv
// Raster sequencer for the HDMI TX datapath: position, syncs, data enable, period mode and
// CTL bits. Every output is registered from the position it accompanies, so there is no skew.
module video_timing_ctrl
    import hdmi_timing_pkg::*;
#(
    parameter int   H_ACTIVE  = VGA_H_ACTIVE,
    parameter int   H_FRONT   = VGA_H_FRONT,
    parameter int   H_SYNC    = VGA_H_SYNC,
    parameter int   H_BACK    = VGA_H_BACK,
    parameter int   V_ACTIVE  = VGA_V_ACTIVE,
    parameter int   V_FRONT   = VGA_V_FRONT,
    parameter int   V_SYNC    = VGA_V_SYNC,
    parameter int   V_BACK    = VGA_V_BACK,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0,
    parameter logic GUARD_EN  = 1'b1
) (
    input  logic       pixelCLK,
    input  logic       reset,
    input  logic       enable,
    output logic [9:0] horizontalPix,
    output logic [9:0] verticalPix,
    output logic       hsync,
    output logic       vsync,
    output logic       videoEnable,
    output logic [1:0] periodMode,
    output logic [3:0] ctlBits,
    output logic       frameStart,
    output logic       lineStart
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HOLD_H  = H_TOTAL - PRE_LEN - GB_LEN - 1;

    localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0] H_ACT_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] HOLD_X     = 10'(HOLD_H);
    localparam logic [9:0] PRE_LAST   = 10'(HOLD_H + PRE_LEN);
    localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0] V_ACT_LAST = 10'(V_ACTIVE - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [9:0]   nextH;
    logic [9:0]   nextV;
    logic         atHold;
    logic         nextLineActive;
    ctrl_state_t  state;
    period_mode_t mode;

    video_timing_counter #(
        .H_TOTAL(H_TOTAL),
        .V_TOTAL(V_TOTAL),
        .HOLD_H (HOLD_H)
    ) u_counter (
        .pixelCLK(pixelCLK),
        .reset   (reset),
        .enable  (enable),
        .h       (horizontalPix),
        .v       (verticalPix),
        .nextH   (nextH),
        .nextV   (nextV),
        .atHold  (atHold)
    );

    // The line after the current one carries pixels; the last frame line wraps to line 0.
    assign nextLineActive = (verticalPix < V_ACT_LAST) || (verticalPix == V_LAST);
    assign periodMode     = mode;

    always_ff @(posedge pixelCLK or posedge reset) begin
        if (reset) begin
            videoEnable <= 1'b0;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            frameStart  <= 1'b0;
            lineStart   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the values from before this edge.
            videoEnable <= (nextH < H_ACT) && (nextV < V_ACT);
            hsync       <= (nextH >= HS_START && nextH < HS_END) ? HSYNC_POL : ~HSYNC_POL;
            vsync       <= (nextV >= VS_START && nextV < VS_END) ? VSYNC_POL : ~VSYNC_POL;
            frameStart  <= (nextH == '0) && (nextV == '0);
            lineStart   <= (nextH == '0);
        end
    end

    // Transitions use the current position; state and mode land together with the counter step.
    always_ff @(posedge pixelCLK or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            mode    <= CONTROL;
            ctlBits <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        if (GUARD_EN) begin
                            state   <= ST_PREAMBLE;
                            mode    <= PREAMBLE;
                            ctlBits <= CTL_VIDEO_PREAMBLE;
                        end else begin
                            state <= ST_BLANK;
                        end
                    end
                end
                ST_BLANK: begin
                    if (atHold && !enable) begin
                        state <= ST_IDLE;
                    end else if (GUARD_EN && horizontalPix == HOLD_X && nextLineActive) begin
                        state   <= ST_PREAMBLE;
                        mode    <= PREAMBLE;
                        ctlBits <= CTL_VIDEO_PREAMBLE;
                    end else if (!GUARD_EN && horizontalPix == H_LAST && nextLineActive) begin
                        state <= ST_ACTIVE;
                        mode  <= VIDEO;
                    end
                end
                ST_PREAMBLE: begin
                    if (horizontalPix == PRE_LAST) begin
                        state   <= ST_GUARD;
                        mode    <= GUARD;
                        ctlBits <= '0;
                    end
                end
                ST_GUARD: begin
                    if (horizontalPix == H_LAST) begin
                        state <= ST_ACTIVE;
                        mode  <= VIDEO;
                    end
                end
                ST_ACTIVE: begin
                    if (horizontalPix == H_ACT_LAST) begin
                        state <= ST_BLANK;
                        mode  <= CONTROL;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    mode    <= CONTROL;
                    ctlBits <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Bench for video_timing_ctrl: a full-size 640x480 instance plus two reduced-raster instances
// (HDMI and DVI) so whole frames fit in a short run; all are compared to a position model.
module tb_video_timing_ctrl;

    typedef struct packed {
        int ha; int hf; int hs; int hb;
        int va; int vf; int vs; int vb;
        bit hpol; bit vpol; bit guard;
    } cfg_t;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       ve;
        logic [1:0] pm;
        logic [3:0] ctl;
        logic       fs;
        logic       ls;
    } obs_t;

    localparam cfg_t CFG_VGA = '{ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33,
                                 hpol: 1'b0, vpol: 1'b0, guard: 1'b1};
    localparam cfg_t CFG_SMALL = '{ha: 20, hf: 4, hs: 6, hb: 12, va: 12, vf: 2, vs: 2, vb: 3,
                                   hpol: 1'b0, vpol: 1'b0, guard: 1'b1};
    localparam cfg_t CFG_DVI = '{ha: 20, hf: 4, hs: 6, hb: 12, va: 12, vf: 2, vs: 2, vb: 3,
                                 hpol: 1'b1, vpol: 1'b1, guard: 1'b0};

    logic       clk;
    logic       reset;
    logic       enable;
    logic [9:0] hPix [3];
    logic [9:0] vPix [3];
    logic       hs   [3];
    logic       vs   [3];
    logic       ve   [3];
    logic [1:0] pm   [3];
    logic [3:0] ctl  [3];
    logic       fs   [3];
    logic       ls   [3];

    int mh [3];
    int mv [3];
    int checks   = 0;
    int failures = 0;
    bit live     = 1'b0;

    video_timing_ctrl #(
        .H_ACTIVE(CFG_VGA.ha), .H_FRONT(CFG_VGA.hf), .H_SYNC(CFG_VGA.hs), .H_BACK(CFG_VGA.hb),
        .V_ACTIVE(CFG_VGA.va), .V_FRONT(CFG_VGA.vf), .V_SYNC(CFG_VGA.vs), .V_BACK(CFG_VGA.vb),
        .HSYNC_POL(CFG_VGA.hpol), .VSYNC_POL(CFG_VGA.vpol), .GUARD_EN(CFG_VGA.guard)
    ) dutVga (
        .pixelCLK(clk), .reset(reset), .enable(enable),
        .horizontalPix(hPix[0]), .verticalPix(vPix[0]), .hsync(hs[0]), .vsync(vs[0]),
        .videoEnable(ve[0]), .periodMode(pm[0]), .ctlBits(ctl[0]),
        .frameStart(fs[0]), .lineStart(ls[0])
    );

    video_timing_ctrl #(
        .H_ACTIVE(CFG_SMALL.ha), .H_FRONT(CFG_SMALL.hf), .H_SYNC(CFG_SMALL.hs), .H_BACK(CFG_SMALL.hb),
        .V_ACTIVE(CFG_SMALL.va), .V_FRONT(CFG_SMALL.vf), .V_SYNC(CFG_SMALL.vs), .V_BACK(CFG_SMALL.vb),
        .HSYNC_POL(CFG_SMALL.hpol), .VSYNC_POL(CFG_SMALL.vpol), .GUARD_EN(CFG_SMALL.guard)
    ) dutSmall (
        .pixelCLK(clk), .reset(reset), .enable(enable),
        .horizontalPix(hPix[1]), .verticalPix(vPix[1]), .hsync(hs[1]), .vsync(vs[1]),
        .videoEnable(ve[1]), .periodMode(pm[1]), .ctlBits(ctl[1]),
        .frameStart(fs[1]), .lineStart(ls[1])
    );

    video_timing_ctrl #(
        .H_ACTIVE(CFG_DVI.ha), .H_FRONT(CFG_DVI.hf), .H_SYNC(CFG_DVI.hs), .H_BACK(CFG_DVI.hb),
        .V_ACTIVE(CFG_DVI.va), .V_FRONT(CFG_DVI.vf), .V_SYNC(CFG_DVI.vs), .V_BACK(CFG_DVI.vb),
        .HSYNC_POL(CFG_DVI.hpol), .VSYNC_POL(CFG_DVI.vpol), .GUARD_EN(CFG_DVI.guard)
    ) dutDvi (
        .pixelCLK(clk), .reset(reset), .enable(enable),
        .horizontalPix(hPix[2]), .verticalPix(vPix[2]), .hsync(hs[2]), .vsync(vs[2]),
        .videoEnable(ve[2]), .periodMode(pm[2]), .ctlBits(ctl[2]),
        .frameStart(fs[2]), .lineStart(ls[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic cfg_t cfgOf(input int i);
        case (i)
            0:       return CFG_VGA;
            1:       return CFG_SMALL;
            default: return CFG_DVI;
        endcase
    endfunction

    function automatic string nameOf(input int i);
        case (i)
            0:       return "vga";
            1:       return "small";
            default: return "dvi";
        endcase
    endfunction

    function automatic int htOf(input cfg_t c);
        return c.ha + c.hf + c.hs + c.hb;
    endfunction

    function automatic int vtOf(input cfg_t c);
        return c.va + c.vf + c.vs + c.vb;
    endfunction

    // What the outputs must be at raster position (h,v), straight from the timing rules.
    function automatic obs_t expectedObs(input cfg_t c, input int h, input int v);
        obs_t e;
        int   ht;
        int   vt;
        bit   nextActive;
        ht = htOf(c);
        vt = vtOf(c);
        e.h  = 10'(h);
        e.v  = 10'(v);
        e.hs = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hs) ? c.hpol : !c.hpol;
        e.vs = (v >= c.va + c.vf && v < c.va + c.vf + c.vs) ? c.vpol : !c.vpol;
        e.ve = (h < c.ha) && (v < c.va);
        nextActive = (v + 1 < c.va) || (v == vt - 1);
        if (e.ve)                                                  e.pm = 2'b11;
        else if (c.guard && nextActive && h >= ht - 10 && h < ht - 2) e.pm = 2'b01;
        else if (c.guard && nextActive && h >= ht - 2)             e.pm = 2'b10;
        else                                                       e.pm = 2'b00;
        e.ctl = (e.pm == 2'b01) ? 4'b0001 : 4'b0000;
        e.fs  = (h == 0) && (v == 0);
        e.ls  = (h == 0);
        return e;
    endfunction

    function automatic obs_t gotObs(input int i);
        obs_t o;
        o.h = hPix[i]; o.v = vPix[i]; o.hs = hs[i]; o.vs = vs[i]; o.ve = ve[i];
        o.pm = pm[i]; o.ctl = ctl[i]; o.fs = fs[i]; o.ls = ls[i];
        return o;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    task automatic stepN(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitSmall(input int h, input int v, input int budget, input string name);
        int n = 0;
        while (!(int'(hPix[1]) == h && int'(vPix[1]) == v) && n < budget) begin
            stepN(1);
            n++;
        end
        check({"reach_", name}, 64'(n < budget), 64'd1);
    endtask

    // Raster position model: parks at the hold point while enable is low, otherwise advances.
    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                mh[i] <= htOf(cfgOf(i)) - 11;
                mv[i] <= vtOf(cfgOf(i)) - 1;
            end else if (!(mh[i] == htOf(cfgOf(i)) - 11 && mv[i] == vtOf(cfgOf(i)) - 1 && !enable)) begin
                if (mh[i] == htOf(cfgOf(i)) - 1) begin
                    mh[i] <= 0;
                    mv[i] <= (mv[i] == vtOf(cfgOf(i)) - 1) ? 0 : mv[i] + 1;
                end else begin
                    mh[i] <= mh[i] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            for (int i = 0; i < 3; i++)
                check($sformatf("cycle_%s_h%0d_v%0d", nameOf(i), mh[i], mv[i]),
                      64'(gotObs(i)), 64'(expectedObs(cfgOf(i), mh[i], mv[i])));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int veCnt, lsCnt, fsCnt, hsCnt, vsCnt;
        int dviVideo, dviIllegal, dviCtl, dviDisagree, dviHs;
        reset  = 1'b1;
        enable = 1'b0;
        stepN(3);
        live = 1'b1;

        // Reset values of the full-size raster
        check("rst_h",     64'(hPix[0]), 64'd789);
        check("rst_v",     64'(vPix[0]), 64'd524);
        check("rst_mode",  64'(pm[0]),   64'd0);
        check("rst_ctl",   64'(ctl[0]),  64'd0);
        check("rst_hsync", 64'(hs[0]),   64'd1);
        check("rst_vsync", 64'(vs[0]),   64'd1);
        check("rst_ve",    64'(ve[0]),   64'd0);
        check("rst_dvi_hsync", 64'(hs[2]), 64'd0);

        reset = 1'b0;
        stepN(4);
        check("hold_h", 64'(hPix[0]), 64'd789);
        check("hold_small_h", 64'(hPix[1]), 64'd31);

        // Start: preamble, guard band, then first active pixel
        enable = 1'b1;
        for (int k = 0; k < 8; k++) begin
            stepN(1);
            check($sformatf("pre_h_%0d", 790 + k), 64'(hPix[0]), 64'(790 + k));
            check("pre_mode", 64'(pm[0]),  64'd1);
            check("pre_ctl",  64'(ctl[0]), 64'd1);
        end
        for (int k = 0; k < 2; k++) begin
            stepN(1);
            check($sformatf("guard_h_%0d", 798 + k), 64'(hPix[0]), 64'(798 + k));
            check("guard_mode", 64'(pm[0]),  64'd2);
            check("guard_ctl",  64'(ctl[0]), 64'd0);
        end
        stepN(1);
        check("first_h",  64'(hPix[0]), 64'd0);
        check("first_v",  64'(vPix[0]), 64'd0);
        check("first_mode", 64'(pm[0]), 64'd3);
        check("first_ve", 64'(ve[0]),   64'd1);
        check("first_fs", 64'(fs[0]),   64'd1);
        check("first_ls", 64'(ls[0]),   64'd1);

        // One whole reduced frame (42 x 19 = 798 pixels)
        veCnt = 0; lsCnt = 0; fsCnt = 0; hsCnt = 0; vsCnt = 0;
        dviVideo = 0; dviIllegal = 0; dviCtl = 0; dviDisagree = 0; dviHs = 0;
        for (int k = 0; k < 798; k++) begin
            if (ve[1]) veCnt++;
            if (ls[1]) lsCnt++;
            if (fs[1]) fsCnt++;
            if (!hs[1]) hsCnt++;
            if (!vs[1]) vsCnt++;
            if (pm[2] == 2'b11) dviVideo++;
            if (pm[2] == 2'b01 || pm[2] == 2'b10) dviIllegal++;
            if (ctl[2] != 4'b0000) dviCtl++;
            if ((pm[2] == 2'b11) != ve[2]) dviDisagree++;
            if (hs[2]) dviHs++;
            stepN(1);
        end
        check("frame_ve_count",   64'(veCnt), 64'd240);
        check("frame_ls_count",   64'(lsCnt), 64'd19);
        check("frame_fs_count",   64'(fsCnt), 64'd1);
        check("frame_hsync_low",  64'(hsCnt), 64'd114);
        check("frame_vsync_low",  64'(vsCnt), 64'd84);
        check("dvi_video_count",  64'(dviVideo), 64'd240);
        check("dvi_no_preamble",  64'(dviIllegal), 64'd0);
        check("dvi_ctl_zero",     64'(dviCtl), 64'd0);
        check("dvi_video_is_ve",  64'(dviDisagree), 64'd0);
        check("dvi_hsync_high",   64'(dviHs), 64'd114);

        // Preamble only precedes active lines
        waitSmall(32, 0, 100, "pre_line0");
        check("pre_line0_mode", 64'(pm[1]), 64'd1);
        check("pre_line0_ctl",  64'(ctl[1]), 64'd1);
        waitSmall(32, 10, 600, "pre_line10");
        check("pre_line10_mode", 64'(pm[1]), 64'd1);
        waitSmall(32, 11, 100, "pre_line11");
        check("no_pre_last_active", 64'(pm[1]), 64'd0);
        check("no_pre_ctl",         64'(ctl[1]), 64'd0);
        waitSmall(32, 18, 400, "pre_line18");
        check("pre_frame_end", 64'(pm[1]), 64'd1);

        // Enable dropped mid-frame: frame completes, then the raster parks
        waitSmall(10, 5, 400, "drop_point");
        enable = 1'b0;
        waitSmall(31, 18, 1000, "park");
        stepN(5);
        check("park_h",    64'(hPix[1]), 64'd31);
        check("park_v",    64'(vPix[1]), 64'd18);
        check("park_mode", 64'(pm[1]),   64'd0);
        check("park_dvi_h", 64'(hPix[2]), 64'd31);
        enable = 1'b1;
        stepN(1);
        check("resume_h",    64'(hPix[1]), 64'd32);
        check("resume_mode", 64'(pm[1]),   64'd1);
        check("resume_dvi_mode", 64'(pm[2]), 64'd0);

        // Asynchronous reset in the middle of a line of the full-size raster
        begin
            int n = 0;
            while (hPix[0] != 10'd300 && n < 900) begin
                stepN(1);
                n++;
            end
            check("reach_vga_h300", 64'(n < 900), 64'd1);
        end
        #2 reset = 1'b1;
        #1;
        check("async_rst_h",     64'(hPix[0]), 64'd789);
        check("async_rst_v",     64'(vPix[0]), 64'd524);
        check("async_rst_mode",  64'(pm[0]),   64'd0);
        check("async_rst_hsync", 64'(hs[0]),   64'd1);
        check("async_rst_ls",    64'(ls[0]),   64'd0);
        stepN(2);
        check("rst_hold_small_h", 64'(hPix[1]), 64'd31);
        reset = 1'b0;
        stepN(1);
        check("post_rst_h",    64'(hPix[0]), 64'd790);
        check("post_rst_mode", 64'(pm[0]),   64'd1);
        stepN(60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
